// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised valid/ready pipeline stage register with a
// 2-entry skid buffer, synchronous flush, and NOP bubbles.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-low reset
//   flush      synchronous kill of held and incoming beats
//   up_valid   upstream beat valid
//   up_ready   stage can accept a beat this cycle (registered)
//   up_pc4     upstream PC+4          [XLEN-1:0]
//   up_instr   upstream instruction   [ILEN-1:0]
//   up_side    upstream sideband      [SIDE_W-1:0]
//   dn_valid   downstream beat valid
//   dn_ready   downstream accepts the beat
//   dn_pc4     held PC+4 (0 when dn_valid=0)
//   dn_instr   held instruction (NOP_INSTR when dn_valid=0)
//   dn_side    held sideband (0 when dn_valid=0)
//
// Optional feature, macro PIPE_STAGE_STATS_EN:
//   stall_cnt  [31:0] cycles with dn_valid=1 & dn_ready=0 (wraps)
//   flush_cnt  [31:0] cycles with flush=1 and any entry valid (wraps)
//
// Handshake: a beat moves on a side when valid and ready are both high at
// the rising edge. A producer holding valid keeps its payload stable until
// it is accepted. up_ready comes only from the skid register, so there is
// no combinational path from dn_ready to up_ready.
//
// State is carried by the two valid bits: EMPTY (none), ONE (main only),
// TWO (main and skid). It is observable as {~up_ready, dn_valid}.

module pipe_stage_reg #(
    parameter int               XLEN      = 32,
    parameter int               ILEN      = 32,
    parameter int               SIDE_W    = 2,
    parameter logic [ILEN-1:0]  NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [XLEN-1:0]   up_pc4,
    input  logic [ILEN-1:0]   up_instr,
    input  logic [SIDE_W-1:0] up_side,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [XLEN-1:0]   dn_pc4,
    output logic [ILEN-1:0]   dn_instr,
    output logic [SIDE_W-1:0] dn_side
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    // Main entry drives the downstream outputs.
    logic              main_valid;
    logic [XLEN-1:0]   main_pc4;
    logic [ILEN-1:0]   main_instr;
    logic [SIDE_W-1:0] main_side;

    // Skid entry catches the beat accepted while downstream is stalled.
    logic              skid_valid;
    logic [XLEN-1:0]   skid_pc4;
    logic [ILEN-1:0]   skid_instr;
    logic [SIDE_W-1:0] skid_side;

    logic up_fire;
    logic dn_fire;

    assign up_ready = ~skid_valid;
    assign dn_valid = main_valid;
    assign up_fire  = up_valid & up_ready;
    assign dn_fire  = main_valid & dn_ready;

    // Payload registers are not reset: they are only observed through the
    // valid bits, which are.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            // Incoming beat is dropped; a same-cycle dn_fire is simply lost
            // from the stage, which is what downstream expects.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // TWO: up_ready is low, so only the drain can happen.
            if (dn_fire) begin
                main_pc4   <= skid_pc4;
                main_instr <= skid_instr;
                main_side  <= skid_side;
                skid_valid <= 1'b0;
            end
        end else if (main_valid) begin
            // ONE
            if (up_fire && dn_fire) begin
                main_pc4   <= up_pc4;
                main_instr <= up_instr;
                main_side  <= up_side;
            end else if (up_fire) begin
                skid_pc4   <= up_pc4;
                skid_instr <= up_instr;
                skid_side  <= up_side;
                skid_valid <= 1'b1;
            end else if (dn_fire) begin
                main_valid <= 1'b0;
            end
        end else if (up_fire) begin
            // EMPTY
            main_pc4   <= up_pc4;
            main_instr <= up_instr;
            main_side  <= up_side;
            main_valid <= 1'b1;
        end
    end

    // Bubbles present a canonical NOP with zeroed pc4/sideband.
    assign dn_pc4   = main_valid ? main_pc4   : '0;
    assign dn_instr = main_valid ? main_instr : NOP_INSTR;
    assign dn_side  = main_valid ? main_side  : '0;

`ifdef PIPE_STAGE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (main_valid && !dn_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (main_valid || skid_valid)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: table-driven and randomized bench for pipe_stage_reg.
// The reference model is a 2-deep FIFO queue (exp_q) of {pc4, instr, side}.

module tb_pipe_stage_reg;

    localparam int XLEN   = 32;
    localparam int ILEN   = 32;
    localparam int SIDE_W = 2;
    localparam int BW     = XLEN + ILEN + SIDE_W;
    localparam logic [31:0] NOP = 32'h00000013;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              up_valid;
    logic              up_ready;
    logic [XLEN-1:0]   up_pc4;
    logic [ILEN-1:0]   up_instr;
    logic [SIDE_W-1:0] up_side;
    logic              dn_valid;
    logic              dn_ready;
    logic [XLEN-1:0]   dn_pc4;
    logic [ILEN-1:0]   dn_instr;
    logic [SIDE_W-1:0] dn_side;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .XLEN(XLEN), .ILEN(ILEN), .SIDE_W(SIDE_W), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready),
        .up_pc4(up_pc4), .up_instr(up_instr), .up_side(up_side),
        .dn_valid(dn_valid), .dn_ready(dn_ready),
        .dn_pc4(dn_pc4), .dn_instr(dn_instr), .dn_side(dn_side)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    int checks   = 0;
    int failures = 0;
    logic [BW-1:0] exp_q[$];   // beats currently held by the stage, oldest first
    logic [31:0]   m_stall = 0;
    logic [31:0]   m_flush = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: inputs already driven; model follows the FIFO rules.
    task automatic cycle();
        bit m_up_fire, m_dn_fire, inc_stall, inc_flush;
        m_up_fire = up_valid && (exp_q.size() < 2);
        m_dn_fire = (exp_q.size() != 0) && dn_ready;
        inc_stall = (exp_q.size() != 0) && !dn_ready;
        inc_flush = flush && (exp_q.size() != 0);
        @(posedge clk);
        #1;
        if (!rst) begin
            exp_q.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (inc_stall) m_stall = m_stall + 1;
            if (inc_flush) m_flush = m_flush + 1;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (m_dn_fire) void'(exp_q.pop_front());
                if (m_up_fire) exp_q.push_back({up_pc4, up_instr, up_side});
            end
        end
    endtask

    task automatic check_model();
        logic [BW-1:0] head;
        chk("rand dn_valid", 64'(dn_valid), 64'(exp_q.size() != 0));
        chk("rand up_ready", 64'(up_ready), 64'(exp_q.size() < 2));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk("rand dn_pc4",   64'(dn_pc4),   64'(head[BW-1 -: XLEN]));
            chk("rand dn_instr", 64'(dn_instr), 64'(head[SIDE_W +: ILEN]));
            chk("rand dn_side",  64'(dn_side),  64'(head[SIDE_W-1:0]));
        end else begin
            chk("rand bubble pc4",   64'(dn_pc4),   64'd0);
            chk("rand bubble instr", 64'(dn_instr), 64'(NOP));
            chk("rand bubble side",  64'(dn_side),  64'd0);
        end
`ifdef PIPE_STAGE_STATS_EN
        chk("rand stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("rand flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic        fl;
        logic        uv;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic [1:0]  side;
        logic        dr;
        logic        e_dv;
        logic        e_ur;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic [1:0]  e_side;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    function automatic vec_t mk(logic r, logic fl, logic uv, logic [31:0] pc4,
                                logic [31:0] instr, logic [1:0] side, logic dr,
                                logic e_dv, logic e_ur, logic [31:0] e_pc4,
                                logic [31:0] e_instr, logic [1:0] e_side);
        vec_t v;
        v.r = r; v.fl = fl; v.uv = uv; v.pc4 = pc4; v.instr = instr;
        v.side = side; v.dr = dr; v.e_dv = e_dv; v.e_ur = e_ur;
        v.e_pc4 = e_pc4; v.e_instr = e_instr; v.e_side = e_side;
        return v;
    endfunction

    initial begin
        // Expected columns describe outputs just after the edge of that row.
        //               r  fl uv pc4     instr          sd dr   dv ur pc4     instr          sd
        // reset held 2 cycles with a beat offered
        vecs[0]  = mk(0, 0, 1, 32'h100, 32'hdeadbeef, 1, 1,  0, 1, 32'h0,  NOP,           0);
        vecs[1]  = mk(0, 0, 1, 32'h100, 32'hdeadbeef, 1, 1,  0, 1, 32'h0,  NOP,           0);
        // streaming, dn_ready=1
        vecs[2]  = mk(1, 0, 1, 32'h4,   32'h00500093, 1, 1,  1, 1, 32'h4,  32'h00500093,  1);
        vecs[3]  = mk(1, 0, 1, 32'h8,   32'h00A00113, 2, 1,  1, 1, 32'h8,  32'h00A00113,  2);
        vecs[4]  = mk(1, 0, 1, 32'hC,   32'h002081B3, 3, 1,  1, 1, 32'hC,  32'h002081B3,  3);
        vecs[5]  = mk(1, 0, 0, 32'h0,   32'h0,        0, 1,  0, 1, 32'h0,  NOP,           0);
        // skid: A then B with dn stalled, extra beat refused, then drain
        vecs[6]  = mk(1, 0, 1, 32'h10,  32'h11111111, 1, 0,  1, 1, 32'h10, 32'h11111111,  1);
        vecs[7]  = mk(1, 0, 1, 32'h14,  32'h22222222, 2, 0,  1, 0, 32'h10, 32'h11111111,  1);
        vecs[8]  = mk(1, 0, 1, 32'h18,  32'h99999999, 3, 0,  1, 0, 32'h10, 32'h11111111,  1);
        vecs[9]  = mk(1, 0, 0, 32'h0,   32'h0,        0, 1,  1, 1, 32'h14, 32'h22222222,  2);
        vecs[10] = mk(1, 0, 0, 32'h0,   32'h0,        0, 1,  0, 1, 32'h0,  NOP,           0);
        // flush with skid full and a beat offered
        vecs[11] = mk(1, 0, 1, 32'h30,  32'h33333333, 3, 0,  1, 1, 32'h30, 32'h33333333,  3);
        vecs[12] = mk(1, 0, 1, 32'h34,  32'h44444444, 0, 0,  1, 0, 32'h30, 32'h33333333,  3);
        vecs[13] = mk(1, 1, 1, 32'h20,  32'h55555555, 1, 0,  0, 1, 32'h0,  NOP,           0);
        vecs[14] = mk(1, 0, 0, 32'h0,   32'h0,        0, 1,  0, 1, 32'h0,  NOP,           0);
        // reset mid-operation in TWO, with handshake attempted
        vecs[15] = mk(1, 0, 1, 32'h40,  32'h66666666, 2, 0,  1, 1, 32'h40, 32'h66666666,  2);
        vecs[16] = mk(1, 0, 1, 32'h44,  32'h77777777, 1, 0,  1, 0, 32'h40, 32'h66666666,  2);
        vecs[17] = mk(0, 1, 1, 32'h48,  32'haaaaaaaa, 3, 1,  0, 1, 32'h0,  NOP,           0);
        vecs[18] = mk(1, 0, 0, 32'h0,   32'h0,        0, 1,  0, 1, 32'h0,  NOP,           0);
        vecs[19] = mk(1, 0, 0, 32'h0,   32'h0,        0, 1,  0, 1, 32'h0,  NOP,           0);
        // flush coinciding with dn_fire: consumed beat is not replayed
        vecs[20] = mk(1, 0, 1, 32'h50,  32'h88888888, 0, 1,  1, 1, 32'h50, 32'h88888888,  0);
        vecs[21] = mk(1, 1, 1, 32'h54,  32'hbbbbbbbb, 2, 1,  0, 1, 32'h0,  NOP,           0);
        vecs[22] = mk(1, 0, 0, 32'h0,   32'h0,        0, 1,  0, 1, 32'h0,  NOP,           0);
    end

    // ---------------- driver / test sequence ----------------
    task automatic drive(input logic r, input logic fl, input logic uv,
                         input logic [31:0] pc4, input logic [31:0] instr,
                         input logic [1:0] side, input logic dr);
        rst = r; flush = fl; up_valid = uv; up_pc4 = pc4;
        up_instr = instr; up_side = side; dn_ready = dr;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;

        // Directed table
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].r, vecs[i].fl, vecs[i].uv, vecs[i].pc4,
                  vecs[i].instr, vecs[i].side, vecs[i].dr);
            cycle();
            chk($sformatf("vec%0d dn_valid", i), 64'(dn_valid), 64'(vecs[i].e_dv));
            chk($sformatf("vec%0d up_ready", i), 64'(up_ready), 64'(vecs[i].e_ur));
            chk($sformatf("vec%0d dn_pc4", i),   64'(dn_pc4),   64'(vecs[i].e_pc4));
            chk($sformatf("vec%0d dn_instr", i), 64'(dn_instr), 64'(vecs[i].e_instr));
            chk($sformatf("vec%0d dn_side", i),  64'(dn_side),  64'(vecs[i].e_side));
        end

`ifdef PIPE_STAGE_STATS_EN
        // Counter sequence: 5 stalled cycles then one flush of a held beat.
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("stats reset stall_cnt", 64'(stall_cnt), 64'd0);
        chk("stats reset flush_cnt", 64'(flush_cnt), 64'd0);
        drive(1, 0, 1, 32'h60, 32'hcccccccc, 1, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        drive(1, 1, 0, 0, 0, 0, 1);
        cycle();
        chk("stats stall_cnt", 64'(stall_cnt), 64'd5);
        chk("stats flush_cnt", 64'(flush_cnt), 64'd1);
        chk("stats flushed dn_valid", 64'(dn_valid), 64'd0);
`endif

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 9) < 7),
                  $urandom, $urandom, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 6));
            cycle();
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline stage register. Successor to the fixed IF/ID latch.
- Carries PC+4, the instruction word and a configurable sideband (branch prediction bits, etc.) between any two stages using valid/ready.
- A 2-entry skid buffer registers the upstream ready path, so upstream stalls do not need a combinational ready chain.
- Synchronous flush kills in-flight contents on branch mispredict or trap; bubbles present a canonical NOP.

Parameters:
- XLEN, 32, width of pc4 fields.
- ILEN, 32, width of instruction fields.
- SIDE_W, 2, width of sideband field (min 1).
- NOP_INSTR, 32'h00000013, instruction value driven on dn_instr when dn_valid=0 (ADDI x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous kill of all held and incoming beats.
- up_valid  in  1  upstream beat valid.
- up_ready  out  1  stage can accept a beat this cycle.
- up_pc4  in  XLEN  upstream PC+4.
- up_instr  in  ILEN  upstream instruction.
- up_side  in  SIDE_W  upstream sideband.
- dn_valid  out  1  downstream beat valid.
- dn_ready  in  1  downstream accepts beat.
- dn_pc4  out  XLEN  held PC+4.
- dn_instr  out  ILEN  held instruction.
- dn_side  out  SIDE_W  held sideband.

Behaviour:
- Storage: main entry (drives dn_*) and skid entry. State is encoded by valid bits as EMPTY, ONE (main only) or TWO (main and skid).
- Handshake:
  - up_fire = up_valid & up_ready.
  - dn_fire = dn_valid & dn_ready.
  - up_ready = ~skid_valid, decoded from the register only; no combinational path from dn_ready.
  - dn_valid = main_valid.
- Transitions on posedge clk, with rst=1 and flush=0:
  - EMPTY: up_fire -> ONE, main <= up beat.
  - ONE, up_fire & dn_fire -> ONE, main <= up beat.
  - ONE, up_fire & ~dn_fire -> TWO, skid <= up beat.
  - ONE, ~up_fire & dn_fire -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: dn_fire -> ONE, main <= skid, skid cleared. Otherwise hold. up_ready=0, so no up_fire is possible.
- Ordering: strict FIFO. A beat is never duplicated or dropped except by flush.
- Holding: while dn_valid=1 & dn_ready=0, dn_pc4/dn_instr/dn_side are stable.
- Bubble outputs: when dn_valid=0, dn_instr=NOP_INSTR, dn_pc4=0, dn_side=0.
- flush=1 (with rst=1):
  - Next state EMPTY; main and skid both invalidated.
  - A beat offered upstream in the same cycle is dropped, even if up_ready=1.
  - A dn_fire in the same cycle still counts as consumed by downstream. The stage does not replay it.
- Reset, rst=0 at posedge:
  - State EMPTY; dn_valid=0; bubble outputs as above.
  - up_ready=1 from the next cycle.
  - Upstream beats offered while rst=0 are ignored.
  - Reset takes priority over flush and over any handshake, including mid-transfer in state TWO.
- Latency: 1 cycle from up_fire to dn_valid when the stage was EMPTY. Throughput is 1 beat/cycle while dn_ready=1.
- Widths: all payload fields pass through unmodified; no arithmetic is done on pc4.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined, two extra 32-bit outputs, both wrap modulo 2^32 and clear on reset:
  - stall_cnt: increments each cycle with dn_valid=1 & dn_ready=0.
  - flush_cnt: increments each cycle with flush=1 and at least one entry valid.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with up_valid=1 -> dn_valid=0, dn_instr=32'h00000013, dn_pc4=0. One cycle after rst=1, up_ready=1.
- Streaming: dn_ready=1; send pc4=0x4,0x8,0xC back-to-back with instrs 0x00500093/0x00A00113/0x002081B3 -> the same sequence appears on dn_* one cycle later, contiguous, dn_valid held high 3 cycles.
- Skid: dn_ready=0; send beats A (pc4=0x10) and B (pc4=0x14) -> up_ready falls to 0 after B, dn shows A stable. Raise dn_ready -> A then B delivered, up_ready returns to 1 after A drains.
- Flush with skid full: state TWO, assert flush with up_valid=1 (pc4=0x20) -> next cycle dn_valid=0, up_ready=1, beat 0x20 never appears downstream.
- Reset mid-operation: state TWO, dn_ready=0, drive rst=0 for 1 cycle -> dn_valid=0, skid empty, no stale beat emerges after rst=1.
- PIPE_STAGE_STATS_EN: hold dn_ready=0 for 5 cycles with dn_valid=1, then one flush -> stall_cnt=5, flush_cnt=1.
